ether_export: RTL and testbench
===============================

ETHER_EXPORT -- requirements
Module: ether_export

Interface
REQ-001 Parameter ADDR_BITS, default `ADDR_BITS (shared package), frame-buffer address width; 2^ADDR_BITS 4-bit pixels.
REQ-002 Parameter PAYLOAD_BYTES, default 1024, pixel bytes per Ethernet frame; 2^ADDR_BITS SHALL be a multiple of 2*PAYLOAD_BYTES.
REQ-003 Parameter DEST_MAC, default 48'hFFFF_FFFF_FFFF, destination MAC.
REQ-004 Parameter SRC_MAC, default 48'h02_00_00_00_00_01, source MAC.
REQ-005 Parameter ETHERTYPE, default 16'h88B5, EtherType field.
REQ-006 Parameter IFG_CYCLES, default 48, idle clocks between frames (12 byte times).
REQ-007 clk_in  input  1  sole clock, 50 MHz RMII reference; all logic on rising edge.
REQ-008 rst_in  input  1  reset, synchronous, active-high.
REQ-009 export_trigger_in  input  1  one-cycle pulse starting export of the whole frame buffer.
REQ-010 read_data_in  input  4  pixel from external buffer (bram_manager), valid one cycle after read_addr_out is presented.
REQ-011 read_addr_out  output  ADDR_BITS  registered pixel read address.
REQ-012 eth_txen  output  1  RMII transmit enable, registered.
REQ-013 eth_txd  output  2  RMII transmit dibit, registered; 2'b00 whenever eth_txen=0.

Function
REQ-014 One export SHALL send 2^ADDR_BITS/(2*PAYLOAD_BYTES) frames back-to-back, covering pixel addresses 0..2^ADDR_BITS-1 in ascending order.
REQ-015 Frame layout: 7x 0x55 preamble, 0xD5 SFD, DEST_MAC, SRC_MAC, ETHERTYPE, 2-byte big-endian frame index (0-based), PAYLOAD_BYTES pixel bytes, 4-byte FCS.
REQ-016 MACs and EtherType SHALL be sent most-significant byte first.
REQ-017 Each byte SHALL be sent as 4 dibits, bits[1:0] first, one dibit per clk_in cycle.
REQ-018 Pixel byte k of the export SHALL be {pixel[2k+1], pixel[2k]} (even address in low nibble).
REQ-019 FCS: CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) over destination MAC through last payload byte, updated per dibit; transmitted value is the bitwise complement, least-significant byte first.
REQ-020 Read scheduling: both addresses of a pixel byte SHALL be issued and their data captured before the byte's first dibit is driven; no transmit stall is permitted.
REQ-021 States: IDLE, PREAMBLE (28 dibits), SFD (4), HEADER (56), INDEX (8), PAYLOAD (4*PAYLOAD_BYTES), FCS (16), IFG (IFG_CYCLES); IFG goes to PREAMBLE if frames remain, else IDLE.
REQ-022 IDLE -> PREAMBLE on export_trigger_in; eth_txen SHALL be 1 on the cycle after the trigger is sampled.
REQ-023 eth_txen SHALL be 1 exactly in PREAMBLE..FCS and 0 in IDLE and IFG.
REQ-024 export_trigger_in SHALL be ignored when not in IDLE; trigger in the cycle the FSM enters IDLE is ignored.
REQ-025 Frame index and pixel address SHALL wrap to 0 after the final frame.
REQ-026 Frame length without preamble/SFD SHALL be 14+2+PAYLOAD_BYTES+4 bytes (1044 at default).

Reset
REQ-027 rst_in SHALL force IDLE, eth_txen=0, eth_txd=2'b00, read_addr_out=0, frame index 0, CRC register 0xFFFFFFFF on the next edge.
REQ-028 rst_in mid-frame SHALL abort immediately (truncated frame, no FCS); a new trigger afterwards restarts at frame 0.

Structure
REQ-029 ADDR_BITS SHALL live in the shared types package/header; frame-layout constants (preamble byte, SFD, field lengths) in the same package.
REQ-030 CRC SHALL be a sub-module eth_crc32: inputs clk_in, rst_in, clear, enable, 2-bit dibit; output 32-bit CRC state.
REQ-031 The pixel buffer is external (bram_manager, 1-cycle read latency); ether_export SHALL not instantiate memory.

Verification
REQ-032 Reset then idle 10 cycles -> eth_txen=0, eth_txd=00, read_addr_out=0 throughout.
REQ-033 Single trigger pulse -> next cycle eth_txen=1, 28 dibits 01 then 01,01,01,11 (SFD), then DEST_MAC dibits all 11.
REQ-034 Buffer filled with 4'hF -> every payload dibit 11; FCS matches software CRC-32 of header+index+0xFF payload; receiver CRC residue 0xDEBB20E3.
REQ-035 Buffer pixel[i]=i[3:0] -> payload bytes 0x10,0x32,0x54,...; frame indices 0,1,2,... ascending; eth_txen low exactly IFG_CYCLES cycles between frames.
REQ-036 Second trigger mid-export -> no effect; total frames = 2^ADDR_BITS/(2*PAYLOAD_BYTES), then IDLE with eth_txen=0.
REQ-037 rst_in asserted mid-payload -> eth_txen=0 next cycle; subsequent trigger restarts with frame index 0, address 0.

Source files
------------

// File: rtl/ether_export_pkg.sv
// Shared types and frame-layout constants for the RMII frame-buffer exporter.
// Holds the default frame-buffer address width and the per-dibit CRC-32 step.
package ether_export_pkg;

  localparam int FB_ADDR_BITS = 12;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int PREAMBLE_DIBITS = 28;
  localparam int SFD_DIBITS      = 4;
  localparam int HEADER_DIBITS   = 56;
  localparam int INDEX_DIBITS    = 8;
  localparam int FCS_DIBITS      = 16;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_HEADER,
    ST_INDEX,
    ST_PAYLOAD,
    ST_FCS,
    ST_IFG
  } state_t;

  // Reflected CRC-32, two bits per call, bit 0 of the dibit enters first.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] dibit);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      c = (c >> 1) ^ ((c[0] ^ dibit[i]) ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Running Ethernet CRC-32 register, advanced by one RMII dibit per enabled cycle.
module eth_crc32
  import ether_export_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear,
  input  logic        enable,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC_INIT;
    end else if (enable) begin
      crc_d = crc32_dibit(crc_q, dibit);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/ether_export.sv
// Streams the whole external frame buffer as back-to-back raw Ethernet frames
// over RMII; outputs are registered from the next-state values.
module ether_export
  import ether_export_pkg::*;
#(
  parameter int          ADDR_BITS     = FB_ADDR_BITS,
  parameter int          PAYLOAD_BYTES = 1024,
  parameter logic [47:0] DEST_MAC      = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC       = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5,
  parameter int          IFG_CYCLES    = 48
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 export_trigger_in,
  input  logic [3:0]           read_data_in,
  output logic [ADDR_BITS-1:0] read_addr_out,
  output logic                 eth_txen,
  output logic [1:0]           eth_txd
);

  localparam int PAYLOAD_DIBITS = 4 * PAYLOAD_BYTES;
  localparam int NUM_FRAMES     = (1 << ADDR_BITS) / (2 * PAYLOAD_BYTES);
  localparam int CNT_W          = $clog2(PAYLOAD_DIBITS + IFG_CYCLES + 64);
  localparam logic [111:0] HDR  = {DEST_MAC, SRC_MAC, ETHERTYPE};

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [15:0]          frame_q, frame_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]           pix_lo_q, pix_lo_d, pix_hi_q, pix_hi_d;
  logic                 txen_q, txen_d;
  logic [1:0]           txd_q, txd_d;
  logic                 crc_clear, crc_enable;
  logic [31:0]          crc_state;
  logic                 last_dibit, prefetch;
  logic [7:0]           tx_byte;
  logic [CNT_W-3:0]     byte_idx;

  function automatic int dibits_in(input state_t s);
    case (s)
      ST_PREAMBLE: return PREAMBLE_DIBITS;
      ST_SFD:      return SFD_DIBITS;
      ST_HEADER:   return HEADER_DIBITS;
      ST_INDEX:    return INDEX_DIBITS;
      ST_PAYLOAD:  return PAYLOAD_DIBITS;
      ST_FCS:      return FCS_DIBITS;
      ST_IFG:      return IFG_CYCLES;
      default:     return 1;
    endcase
  endfunction

  eth_crc32 u_crc (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clear   (crc_clear),
    .enable  (crc_enable),
    .dibit   (txd_d),
    .crc_out (crc_state)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      frame_q  <= '0;
      addr_q   <= '0;
      pix_lo_q <= '0;
      pix_hi_q <= '0;
      txen_q   <= 1'b0;
      txd_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      addr_q   <= addr_d;
      pix_lo_q <= pix_lo_d;
      pix_hi_q <= pix_hi_d;
      txen_q   <= txen_d;
      txd_q    <= txd_d;
    end
  end

  assign last_dibit = (int'(cnt_q) == dibits_in(state_q) - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    frame_d = frame_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (export_trigger_in) state_d = ST_PREAMBLE;
    end else if (last_dibit) begin
      cnt_d = '0;
      case (state_q)
        ST_PREAMBLE: state_d = ST_SFD;
        ST_SFD:      state_d = ST_HEADER;
        ST_HEADER:   state_d = ST_INDEX;
        ST_INDEX:    state_d = ST_PAYLOAD;
        ST_PAYLOAD:  state_d = ST_FCS;
        ST_FCS:      state_d = ST_IFG;
        ST_IFG: begin
          if (frame_q == 16'(NUM_FRAMES - 1)) begin
            state_d = ST_IDLE;
            frame_d = '0;
          end else begin
            state_d = ST_PREAMBLE;
            frame_d = frame_q + 16'd1;
          end
        end
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // The pixel pair for a payload byte is fetched during the byte before it:
  // addresses on dibits 0/1, data captured on dibits 1/2. The pair is still
  // intact whenever a dibit of the byte being sent is drawn from it.
  always_comb begin
    byte_idx = cnt_d[CNT_W-1:2];
    tx_byte  = 8'h00;
    case (state_d)
      ST_PREAMBLE: tx_byte = PREAMBLE_BYTE;
      ST_SFD:      tx_byte = SFD_BYTE;
      ST_HEADER:   tx_byte = 8'(HDR >> (8 * (13 - int'(byte_idx))));
      ST_INDEX:    tx_byte = byte_idx[0] ? frame_q[7:0] : frame_q[15:8];
      ST_PAYLOAD:  tx_byte = {pix_hi_q, pix_lo_q};
      ST_FCS:      tx_byte = 8'(~crc_state >> (8 * int'(byte_idx)));
      default:     tx_byte = 8'h00;
    endcase

    txen_d = state_d inside {ST_PREAMBLE, ST_SFD, ST_HEADER, ST_INDEX, ST_PAYLOAD, ST_FCS};
    txd_d  = txen_d ? tx_byte[{cnt_d[1:0], 1'b0} +: 2] : 2'b00;

    crc_clear  = state_d inside {ST_IDLE, ST_PREAMBLE, ST_SFD};
    crc_enable = state_d inside {ST_HEADER, ST_INDEX, ST_PAYLOAD};

    prefetch = (state_q == ST_INDEX && cnt_q[2]) ||
               (state_q == ST_PAYLOAD && int'(cnt_q[CNT_W-1:2]) < PAYLOAD_BYTES - 1);
    addr_d   = addr_q;
    pix_lo_d = pix_lo_q;
    pix_hi_d = pix_hi_q;
    if (prefetch) begin
      if (!cnt_q[1])           addr_d   = addr_q + 1'b1;
      if (cnt_q[1:0] == 2'd1)  pix_lo_d = read_data_in;
      if (cnt_q[1:0] == 2'd2)  pix_hi_d = read_data_in;
    end
  end

  assign read_addr_out = addr_q;
  assign eth_txen      = txen_q;
  assign eth_txd       = txd_q;

endmodule

// File: tb/tb_ether_export.sv
// Scoreboard bench: stimulus queues reference frames built from the buffer
// image; a monitor reassembles RMII frames and compares them as they finish.
module tb_ether_export;

  localparam int A    = 6;
  localparam int P    = 8;
  localparam int IFG  = 10;
  localparam int NF   = (1 << A) / (2 * P);
  localparam int FLEN = 8 + 14 + 2 + P + 4;
  localparam logic [47:0] DMAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SMAC  = 48'h02_00_00_00_00_01;
  localparam logic [15:0] ETYPE = 16'h88B5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         trig = 1'b0;
  logic [3:0]   rd_data;
  logic [A-1:0] rd_addr;
  logic         txen;
  logic [1:0]   txd;
  logic [3:0]   mem [0:(1<<A)-1];

  int total = 0;
  int bad = 0;

  logic [7:0] exp_bytes[$];
  int         exp_idx[$];
  logic [7:0] rx[$];
  int         frames_done = 0;
  bit         in_frame = 0;
  bit         abort_pending = 0;
  int         low_cnt = 0;
  int         gap_seen = 0;
  int         dcnt = 0;
  logic [7:0] cur = 8'h00;

  always #5 clk = ~clk;

  ether_export #(.ADDR_BITS(A), .PAYLOAD_BYTES(P), .IFG_CYCLES(IFG)) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .export_trigger_in (trig),
    .read_data_in      (rd_data),
    .read_addr_out     (rd_addr),
    .eth_txen          (txen),
    .eth_txd           (txd)
  );

  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic push_frame(input int f);
    logic [7:0]  fr[$];
    logic [31:0] crc;
    logic [47:0] d, s;
    d = DMAC;
    s = SMAC;
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 6; i++) fr.push_back(8'(d >> (40 - 8 * i)));
    for (int i = 0; i < 6; i++) fr.push_back(8'(s >> (40 - 8 * i)));
    fr.push_back(ETYPE[15:8]);
    fr.push_back(ETYPE[7:0]);
    fr.push_back(8'(f >> 8));
    fr.push_back(8'(f));
    for (int k = 0; k < P; k++) fr.push_back({mem[f*2*P + 2*k + 1], mem[f*2*P + 2*k]});
    crc = 32'hFFFF_FFFF;
    for (int i = 8; i < fr.size(); i++) crc = crc_byte(crc, fr[i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) fr.push_back(8'(crc >> (8 * i)));
    foreach (fr[i]) exp_bytes.push_back(fr[i]);
    exp_idx.push_back(f);
  endtask

  task automatic check_frame();
    int f, nbad, first;
    logic [31:0] res;
    logic [7:0] e;
    if (abort_pending) begin
      abort_pending = 0;
      return;
    end
    total++;
    if (exp_idx.size() == 0) begin
      bad++;
      $display("FAIL unexpected_frame: got %0d bytes, expected no frame", rx.size());
      return;
    end
    f = exp_idx.pop_front();
    check("frame_len", rx.size(), FLEN);
    nbad = 0;
    first = -1;
    for (int i = 0; i < FLEN; i++) begin
      e = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'hxx;
      if (i >= rx.size() || rx[i] !== e) begin
        nbad++;
        if (first < 0) first = i;
      end
    end
    check("frame_byte_errors", nbad, 0);
    if (nbad != 0) $display("  frame %0d first differing byte at %0d", f, first);
    if (rx.size() == FLEN) begin
      check("frame_index", {rx[22], rx[23]}, f);
      res = 32'hFFFF_FFFF;
      for (int i = 8; i < FLEN; i++) res = crc_byte(res, rx[i]);
      check("crc_residue", res, 32'hDEBB20E3);
    end
    if (f > 0) check("ifg_gap", gap_seen, IFG);
    $display("frame %0d received: %0d bytes, gap %0d", f, rx.size(), gap_seen);
    frames_done++;
  endtask

  always @(negedge clk) begin
    if (txen) begin
      if (!in_frame) begin
        in_frame = 1;
        rx.delete();
        dcnt = 0;
        gap_seen = low_cnt;
      end
      cur[dcnt*2 +: 2] = txd;
      dcnt++;
      if (dcnt == 4) begin
        rx.push_back(cur);
        dcnt = 0;
      end
    end else begin
      check("idle_txd", txd, 2'b00);
      if (in_frame) begin
        in_frame = 0;
        check_frame();
        low_cnt = 0;
      end
      low_cnt++;
    end
  end

  task automatic start_export();
    for (int f = 0; f < NF; f++) push_frame(f);
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    check("txen_after_trigger", txen, 1'b1);
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("frames_done", frames_done, target);
    repeat (IFG + 6) @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << A); i++) mem[i] = 4'h0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_txen", txen, 1'b0);
      check("reset_txd", txd, 2'b00);
      check("reset_addr", rd_addr, 0);
    end

    // All-ones buffer, with a stray trigger part-way through the export.
    for (int i = 0; i < (1 << A); i++) mem[i] = 4'hF;
    start_export();
    repeat (200) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_frames(NF);
    check("queue_empty_1", exp_idx.size(), 0);
    check("idle_after_export", txen, 1'b0);

    // Ramp buffer: payload 0x10, 0x32, ...
    for (int i = 0; i < (1 << A); i++) mem[i] = 4'(i);
    start_export();
    wait_frames(2 * NF);

    for (int i = 0; i < (1 << A); i++) mem[i] = 4'($urandom_range(0, 15));
    start_export();
    wait_frames(3 * NF);

    // Reset during the payload of frame 1, then a fresh export from frame 0.
    for (int i = 0; i < (1 << A); i++) mem[i] = 4'($urandom_range(0, 15));
    start_export();
    n = 0;
    while (!(frames_done > 3 * NF && in_frame && rx.size() >= 26) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("reached_payload", (n < 4000) ? 1 : 0, 1);
    abort_pending = 1;
    exp_idx.delete();
    exp_bytes.delete();
    rst = 1'b1;
    @(negedge clk);
    check("abort_txen", txen, 1'b0);
    check("abort_addr", rd_addr, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < (1 << A); i++) mem[i] = 4'($urandom_range(0, 15));
    start_export();
    wait_frames(4 * NF + 1);
    check("queue_empty_end", exp_idx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
